button_input_ctrl: RTL and testbench



---
 rtl/stopwatch_pkg.sv | 29 ++
 rtl/btn_debounce.sv | 67 ++++++
 rtl/button_input_ctrl.sv | 96 +++++++++
 tb/tb_button_input_ctrl.sv | 238 +++++++++++++++++++++++
 4 files changed

// File: rtl/stopwatch_pkg.sv
`default_nettype none
// ============================================================================
// Module   : stopwatch_pkg
// Purpose  : Shared constants and types for the stopwatch button front end.
//            Provides the button bit positions used on every 3-bit button
//            vector, the run/idle state encoding and the default debounce
//            timing (10 ms at 50 MHz).
// Ports    : none (package)
// Revision : 1.0 - initial release
// ============================================================================
package stopwatch_pkg;

    // Bit positions inside the {clear, stop, start} button vectors
    localparam int BTN_START = 0;
    localparam int BTN_STOP  = 1;
    localparam int BTN_CLEAR = 2;
    localparam int NUM_BTN   = 3;

    // Default debounce timing: 500000 cycles = 10 ms at 50 MHz
    localparam int DEF_DB_CYCLES = 500000;
    localparam int DEF_CNT_W     = 19;

    typedef enum logic [0:0] {
        IDLE    = 1'b0,
        RUNNING = 1'b1
    } run_state_t;

endpackage : stopwatch_pkg
`default_nettype wire

// File: rtl/btn_debounce.sv
`default_nettype none
// ============================================================================
// Module   : btn_debounce
// Purpose  : One push-button channel: 2-flop synchronizer, counter based
//            debounce and rising-edge press pulse.
// Ports    : clock   - system clock, rising edge
//            reset_n - asynchronous active-low reset
//            raw     - raw button level, asynchronous to clock
//            level   - debounced level (registered)
//            press   - one-cycle pulse on the debounced 0->1 transition
// Revision : 1.0 - initial release
// ============================================================================
module btn_debounce
    import stopwatch_pkg::*;
#(
    parameter int DB_CYCLES = DEF_DB_CYCLES,
    parameter int CNT_W     = DEF_CNT_W
) (
    input  logic clock,
    input  logic reset_n,
    input  logic raw,
    output logic level,
    output logic press
);

    localparam logic [CNT_W-1:0] C_CNT_MAX = CNT_W'(DB_CYCLES - 1);

    logic             r_meta;
    logic             r_sync;
    logic             r_stable;
    logic [CNT_W-1:0] r_cnt;
    logic             r_press;
    logic             w_accept;

    // The synchronized input has disagreed with the stable level for the
    // full debounce window on this edge, so the new value is taken.
    assign w_accept = (r_sync != r_stable) && (r_cnt == C_CNT_MAX);

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_meta   <= 1'b0;
            r_sync   <= 1'b0;
            r_stable <= 1'b0;
            r_cnt    <= '0;
            r_press  <= 1'b0;
        end else begin
            r_meta <= raw;
            r_sync <= r_meta;
            if (r_sync == r_stable) begin
                // Any return to agreement restarts the window
                r_cnt <= '0;
            end else if (r_cnt == C_CNT_MAX) begin
                r_stable <= r_sync;
                r_cnt    <= '0;
            end else begin
                r_cnt <= r_cnt + 1'b1;
            end
            // Pulse lands on the same edge as the stable 0->1 update
            r_press <= w_accept & r_sync;
        end
    end

    assign level = r_stable;
    assign press = r_press;

endmodule : btn_debounce
`default_nettype wire

// File: rtl/button_input_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : button_input_ctrl
// Purpose  : Stopwatch input front end. Debounces start/stop/clear buttons
//            and runs the run/idle state machine producing the run level and
//            a one-cycle digit clear request.
// Ports    : clock       - system clock, 50 MHz, rising edge
//            reset_n     - asynchronous active-low reset
//            start_raw   - raw start button, active-high
//            stop_raw    - raw stop button, active-high
//            clear_raw   - raw clear button, active-high
//            btn_level   - debounced levels {clear, stop, start}
//            btn_press   - one-cycle press pulses, same bit order
//            run         - 1 while the stopwatch is counting
//            clear_pulse - one-cycle digit clear request
// Revision : 1.0 - initial release
// ============================================================================
module button_input_ctrl
    import stopwatch_pkg::*;
#(
    parameter int DB_CYCLES = DEF_DB_CYCLES,
    parameter int CNT_W     = DEF_CNT_W
) (
    input  logic               clock,
    input  logic               reset_n,
    input  logic               start_raw,
    input  logic               stop_raw,
    input  logic               clear_raw,
    output logic [NUM_BTN-1:0] btn_level,
    output logic [NUM_BTN-1:0] btn_press,
    output logic               run,
    output logic               clear_pulse
);

    logic [NUM_BTN-1:0] w_raw;
    run_state_t         r_state;
    run_state_t         w_state_nxt;
    logic               r_clear;
    logic               w_clear_nxt;

    assign w_raw = {clear_raw, stop_raw, start_raw};

    for (genvar gi = 0; gi < NUM_BTN; gi++) begin : g_ch
        btn_debounce #(
            .DB_CYCLES (DB_CYCLES),
            .CNT_W     (CNT_W)
        ) u_db (
            .clock   (clock),
            .reset_n (reset_n),
            .raw     (w_raw[gi]),
            .level   (btn_level[gi]),
            .press   (btn_press[gi])
        );
    end

    always_comb begin
        w_state_nxt = r_state;
        w_clear_nxt = 1'b0;
        case (r_state)
            IDLE: begin
                // Stop wins over a simultaneous start
                if (btn_press[BTN_START] && !btn_press[BTN_STOP]) begin
                    w_state_nxt = RUNNING;
                end
                if (btn_press[BTN_CLEAR]) begin
                    w_clear_nxt = 1'b1;
                end
            end
            RUNNING: begin
                // Start and clear presses are ignored while counting,
                // including a clear arriving with the stopping press.
                if (btn_press[BTN_STOP]) begin
                    w_state_nxt = IDLE;
                end
            end
            default: begin
                w_state_nxt = IDLE;
            end
        endcase
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_state <= IDLE;
            r_clear <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_clear <= w_clear_nxt;
        end
    end

    assign run         = (r_state == RUNNING);
    assign clear_pulse = r_clear;

endmodule : button_input_ctrl
`default_nettype wire

// File: tb/tb_button_input_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_button_input_ctrl
// Purpose  : Self-checking bench for button_input_ctrl with DB_CYCLES=8.
//            A cycle model built from the raw-input history predicts all
//            outputs; predictions are queued at each rising edge and compared
//            on the following falling edge. Directed checks cover latency,
//            bounce rejection, priority, clear gating and async reset.
// Ports    : none
// Revision : 1.0 - initial release
// ============================================================================
module tb_button_input_ctrl;
    import stopwatch_pkg::*;

    localparam int DB = 8;
    localparam int CW = 4;

    logic       clock;
    logic       reset_n;
    logic [2:0] raw_in;
    logic [2:0] btn_level;
    logic [2:0] btn_press;
    logic       run;
    logic       clear_pulse;

    int compared   = 0;
    int mismatched = 0;

    button_input_ctrl #(
        .DB_CYCLES (DB),
        .CNT_W     (CW)
    ) dut (
        .clock       (clock),
        .reset_n     (reset_n),
        .start_raw   (raw_in[BTN_START]),
        .stop_raw    (raw_in[BTN_STOP]),
        .clear_raw   (raw_in[BTN_CLEAR]),
        .btn_level   (btn_level),
        .btn_press   (btn_press),
        .run         (run),
        .clear_pulse (clear_pulse)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        compared++;
        if (obs !== exp) begin
            mismatched++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    // ---------------- reference model + scoreboard ----------------
    // A channel flips once its last DB synchronized samples all disagree
    // with the current debounced level.
    logic [7:0]    sb_q[$];
    logic [2:0]    m_s1, m_s2, m_stable, m_press;
    logic [DB-1:0] m_hist [3];
    logic          m_run, m_clr;

    always @(posedge clock) begin
        logic [2:0] np;
        logic       nrun, nclr, flip;
        if (!reset_n) begin
            m_s1 = '0; m_s2 = '0; m_stable = '0; m_press = '0;
            m_run = 1'b0; m_clr = 1'b0;
            for (int c = 0; c < 3; c++) m_hist[c] = '0;
        end else begin
            nrun = m_run;
            nclr = 1'b0;
            if (!m_run) begin
                if (m_press[0] && !m_press[1]) nrun = 1'b1;
                if (m_press[2]) nclr = 1'b1;
            end else if (m_press[1]) begin
                nrun = 1'b0;
            end
            for (int c = 0; c < 3; c++) begin
                m_hist[c] = {m_hist[c][DB-2:0], m_s2[c]};
                flip  = (m_hist[c] == {DB{~m_stable[c]}});
                np[c] = flip && !m_stable[c];
                if (flip) m_stable[c] = ~m_stable[c];
            end
            m_s2 = m_s1;
            m_s1 = raw_in;
            m_press = np;
            m_run = nrun;
            m_clr = nclr;
        end
        sb_q.push_back({m_stable, m_press, m_run, m_clr});
    end

    // ---------------- monitors ----------------
    int press_cnt [3] = '{0, 0, 0};
    int clr_cnt  = 0;
    int cnt_max  = 0;
    int both_cnt = 0;

    always @(negedge clock) begin
        logic [7:0] exp;
        if (sb_q.size() > 0) begin
            exp = sb_q.pop_front();
            check("sb_outputs", 32'({btn_level, btn_press, run, clear_pulse}), 32'(exp));
        end
        for (int c = 0; c < 3; c++) if (btn_press[c]) press_cnt[c]++;
        if (btn_press[1:0] == 2'b11) both_cnt++;
        if (clear_pulse) clr_cnt++;
        if (int'(dut.g_ch[0].u_db.r_cnt) > cnt_max) cnt_max = int'(dut.g_ch[0].u_db.r_cnt);
        if (int'(dut.g_ch[1].u_db.r_cnt) > cnt_max) cnt_max = int'(dut.g_ch[1].u_db.r_cnt);
        if (int'(dut.g_ch[2].u_db.r_cnt) > cnt_max) cnt_max = int'(dut.g_ch[2].u_db.r_cnt);
    end

    // ---------------- stimulus helpers ----------------
    // Returns just after a falling edge, away from the sampling edge.
    task automatic wait_cycles(input int n);
        repeat (n) @(negedge clock);
        #2;
    endtask

    // Counts rising edges until the debounced level reaches val (bounded).
    task automatic wait_level(input int ch, input logic val, output int edges);
        edges = 0;
        for (int k = 0; k < 40; k++) begin
            @(posedge clock);
            #1;
            edges++;
            if (btn_level[ch] == val) break;
        end
    endtask

    task automatic tap(input int ch);
        raw_in[ch] = 1'b1;
        wait_cycles(14);
        raw_in[ch] = 1'b0;
        wait_cycles(14);
    endtask

    int e, pc0, pc1, pcl, pb;

    initial begin
        reset_n = 1'b0;
        raw_in  = 3'b000;
        wait_cycles(3);
        check("reset_outputs", 32'({btn_level, btn_press, run, clear_pulse}), 32'd0);
        reset_n = 1'b1;
        wait_cycles(2);

        // Clean start press
        raw_in[0] = 1'b1;
        wait_level(0, 1'b1, e);
        check("start_latency", 32'(e), 32'd10);
        check("start_press", 32'(btn_press[0]), 32'd1);
        check("run_before_edge", 32'(run), 32'd0);
        @(posedge clock); #1;
        check("start_press_width", 32'(btn_press[0]), 32'd0);
        check("run_rise", 32'(run), 32'd1);
        wait_cycles(8);
        raw_in[0] = 1'b0;
        wait_level(0, 1'b0, e);
        check("release_latency", 32'(e), 32'd10);
        wait_cycles(2);
        tap(1);
        check("stop_to_idle", 32'(run), 32'd0);

        // Bouncing start
        pc0 = press_cnt[0];
        for (int k = 0; k < 10; k++) begin
            raw_in[0] = (k % 2 == 0);
            wait_cycles(3);
        end
        check("bounce_no_press", 32'(press_cnt[0] - pc0), 32'd0);
        check("bounce_run_low", 32'(run), 32'd0);
        raw_in[0] = 1'b1;
        wait_level(0, 1'b1, e);
        check("bounce_latency", 32'(e), 32'd10);
        wait_cycles(12);
        check("bounce_one_press", 32'(press_cnt[0] - pc0), 32'd1);
        check("bounce_run", 32'(run), 32'd1);
        raw_in[0] = 1'b0;
        wait_cycles(14);
        tap(1);

        // Start and stop together while idle
        pc0 = press_cnt[0];
        pc1 = press_cnt[1];
        pb  = both_cnt;
        raw_in[1:0] = 2'b11;
        wait_cycles(14);
        check("both_pressed_together", 32'(both_cnt - pb), 32'd1);
        check("both_start_cnt", 32'(press_cnt[0] - pc0), 32'd1);
        check("both_stop_cnt", 32'(press_cnt[1] - pc1), 32'd1);
        check("both_run_low", 32'(run), 32'd0);
        raw_in[1:0] = 2'b00;
        wait_cycles(14);

        // Clear gating
        tap(0);
        check("run_for_clear", 32'(run), 32'd1);
        pcl = clr_cnt;
        tap(2);
        check("clear_while_running", 32'(clr_cnt - pcl), 32'd0);
        tap(1);
        check("run_after_stop", 32'(run), 32'd0);
        tap(2);
        check("clear_while_idle", 32'(clr_cnt - pcl), 32'd1);

        // Async reset mid-debounce while running
        tap(0);
        check("run_before_reset", 32'(run), 32'd1);
        raw_in[0] = 1'b1;
        wait_cycles(5);
        reset_n = 1'b0;
        #1;
        check("async_reset", 32'({btn_level, btn_press, run, clear_pulse}), 32'd0);
        wait_cycles(3);
        reset_n = 1'b1;
        wait_level(0, 1'b1, e);
        check("post_reset_latency", 32'(e), 32'd10);
        check("post_reset_press", 32'(btn_press[0]), 32'd1);
        @(posedge clock); #1;
        check("post_reset_run", 32'(run), 32'd1);

        // Long hold while running
        pc0 = press_cnt[0];
        wait_cycles(1000);
        check("hold_no_press", 32'(press_cnt[0] - pc0), 32'd0);
        check("hold_run", 32'(run), 32'd1);
        check("cnt_max", 32'(cnt_max), 32'(DB - 1));
        raw_in[0] = 1'b0;
        wait_cycles(14);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule : tb_button_input_ctrl
`default_nettype wire
